i2s_apb_regfile: RTL and testbench



---
 rtl/i2s_apb_regfile.sv | 173 +++++++++++++++++
 tb/tb_i2s_apb_regfile.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/i2s_apb_regfile.sv
// APB register file for the I2S transceiver: CTRL/STATUS, Tx/Rx staging buffers, interrupt enable/status.
// Optional byte-lane write strobes are enabled with `define I2S_REGFILE_PSTRB_EN.
module i2s_apb_regfile #(
    parameter int DATA_W   = 32,
    parameter int CTRL_W   = 15,
    parameter int FLAG_W   = 13,
    parameter int TX_DEPTH = 2,
    parameter int RX_DEPTH = 2,
    parameter logic [CTRL_W-1:0] CTRL_RST = CTRL_W'(15'h06D5)
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [7:0]        paddr,
    input  logic [31:0]       pwdata,
`ifdef I2S_REGFILE_PSTRB_EN
    input  logic [3:0]        pstrb,
`endif
    output logic [31:0]       prdata,
    output logic              pready,
    output logic              pslverr,
    input  logic [FLAG_W-1:0] flags,
    output logic [CTRL_W-1:0] controls,
    input  logic              tx_full,
    output logic              tx_wen,
    output logic [DATA_W-1:0] tx_data,
    input  logic              rx_empty,
    output logic              rx_ren,
    input  logic [DATA_W-1:0] rx_data,
    output logic              irq
);
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int TX_CW = TX_AW + 1;
    localparam int RX_CW = RX_AW + 1;
    localparam logic [TX_CW-1:0] TX_FULL = TX_CW'(TX_DEPTH);
    localparam logic [RX_CW-1:0] RX_FULL = RX_CW'(RX_DEPTH);

    logic [CTRL_W-1:0] ctrl_reg;
    logic [3:0]        irq_en_reg;
    logic              tx_ovf_reg, rx_udf_reg, irq_reg;
    logic [DATA_W-1:0] tx_mem [TX_DEPTH];
    logic [DATA_W-1:0] rx_mem [RX_DEPTH];
    logic [TX_AW-1:0]  tx_wptr_reg, tx_rptr_reg;
    logic [RX_AW-1:0]  rx_wptr_reg, rx_rptr_reg;
    logic [TX_CW-1:0]  tx_cnt_reg;
    logic [RX_CW-1:0]  rx_cnt_reg;
    logic              tx_wen_reg, rx_ren_reg, rx_cap_reg;
    logic [DATA_W-1:0] tx_data_reg;

    logic [CTRL_W-1:0] ctrl_mask;
    logic [3:0]        en_mask;
    logic              strb_full;

`ifdef I2S_REGFILE_PSTRB_EN
    genvar gi;
    for (gi = 0; gi < CTRL_W; gi++) begin : g_ctrl_mask
        assign ctrl_mask[gi] = pstrb[gi/8];
    end
    assign en_mask   = {4{pstrb[0]}};
    assign strb_full = &pstrb;
`else
    assign ctrl_mask = '1;
    assign en_mask   = '1;
    assign strb_full = 1'b1;
`endif

    logic        access, wr_acc, rd_acc;
    logic        tx_is_full, tx_push, tx_pop, tx_ovf_set;
    logic        rx_pop, rx_udf_set, rx_issue;
    logic [1:0]  w1c;
    logic [3:0]  irq_stat;
    logic [31:0] status, rdata_mux;
    logic        err;

    always_comb begin
        access     = psel & penable;
        wr_acc     = access & pwrite;
        rd_acc     = access & ~pwrite;
        tx_is_full = (tx_cnt_reg == TX_FULL);
        // Full is judged on the registered count: a same-cycle drain never admits a push.
        tx_push    = wr_acc & (paddr == 8'h08) & strb_full & ~tx_is_full;
        tx_ovf_set = wr_acc & (paddr == 8'h08) & strb_full & tx_is_full;
        tx_pop     = (tx_cnt_reg != '0) & ~tx_full;
        rx_pop     = rd_acc & (paddr == 8'h0C) & (rx_cnt_reg != '0);
        rx_udf_set = rd_acc & (paddr == 8'h0C) & (rx_cnt_reg == '0);
        rx_issue   = ~rx_empty & ~rx_ren_reg & ~rx_cap_reg & (rx_cnt_reg < RX_FULL);
        w1c        = (wr_acc & (paddr == 8'h14)) ? (pwdata[3:2] & en_mask[3:2]) : 2'b00;
        irq_stat   = {rx_udf_reg, tx_ovf_reg, (rx_cnt_reg != '0), (tx_cnt_reg == '0)};
        status     = (32'(tx_cnt_reg) << 24) | (32'(rx_cnt_reg) << 16) | 32'(flags);

        rdata_mux = '0;
        err       = 1'b0;
        case (paddr)
            8'h00: rdata_mux = 32'(ctrl_reg);
            8'h04: begin rdata_mux = status; err = pwrite; end
            8'h08: err = ~pwrite | ~strb_full | tx_is_full;
            8'h0C: begin
                err = pwrite | (rx_cnt_reg == '0);
                if (rx_cnt_reg != '0)
                    rdata_mux = 32'(rx_mem[rx_rptr_reg]);
            end
            8'h10: rdata_mux = 32'(irq_en_reg);
            8'h14: rdata_mux = 32'(irq_stat);
            default: err = 1'b1;
        endcase
        prdata  = rd_acc ? rdata_mux : '0;
        pslverr = access & err;
    end

    assign pready   = 1'b1;
    assign controls = ctrl_reg;
    assign tx_wen   = tx_wen_reg;
    assign tx_data  = tx_data_reg;
    assign rx_ren   = rx_ren_reg;
    assign irq      = irq_reg;

    // Buffer storage carries no reset; the pointers and counts define validity.
    always_ff @(posedge pclk) begin
        if (tx_push)
            tx_mem[tx_wptr_reg] <= pwdata[DATA_W-1:0];
        if (rx_cap_reg)
            rx_mem[rx_wptr_reg] <= rx_data;
    end

    always_ff @(posedge pclk) begin
        if (!preset) begin
            ctrl_reg    <= CTRL_RST;
            irq_en_reg  <= '0;
            tx_ovf_reg  <= 1'b0;
            rx_udf_reg  <= 1'b0;
            irq_reg     <= 1'b0;
            tx_wptr_reg <= '0;
            tx_rptr_reg <= '0;
            tx_cnt_reg  <= '0;
            tx_wen_reg  <= 1'b0;
            tx_data_reg <= '0;
            rx_wptr_reg <= '0;
            rx_rptr_reg <= '0;
            rx_cnt_reg  <= '0;
            rx_ren_reg  <= 1'b0;
            rx_cap_reg  <= 1'b0;
        end else begin
            if (wr_acc && paddr == 8'h00)
                ctrl_reg <= (ctrl_reg & ~ctrl_mask) | (pwdata[CTRL_W-1:0] & ctrl_mask);
            if (wr_acc && paddr == 8'h10)
                irq_en_reg <= (irq_en_reg & ~en_mask) | (pwdata[3:0] & en_mask);
            tx_ovf_reg <= tx_ovf_set | (tx_ovf_reg & ~w1c[0]);
            rx_udf_reg <= rx_udf_set | (rx_udf_reg & ~w1c[1]);
            irq_reg    <= |(irq_stat & irq_en_reg);

            if (tx_push)
                tx_wptr_reg <= tx_wptr_reg + TX_AW'(1);
            tx_wen_reg <= tx_pop;
            if (tx_pop) begin
                tx_data_reg <= tx_mem[tx_rptr_reg];
                tx_rptr_reg <= tx_rptr_reg + TX_AW'(1);
            end
            tx_cnt_reg <= tx_cnt_reg + TX_CW'(tx_push) - TX_CW'(tx_pop);

            // One outstanding read: strobe, then capture the word on the following cycle.
            rx_ren_reg <= rx_issue;
            rx_cap_reg <= rx_ren_reg;
            if (rx_cap_reg)
                rx_wptr_reg <= rx_wptr_reg + RX_AW'(1);
            if (rx_pop)
                rx_rptr_reg <= rx_rptr_reg + RX_AW'(1);
            rx_cnt_reg <= rx_cnt_reg + RX_CW'(rx_cap_reg) - RX_CW'(rx_pop);
        end
    end
endmodule

// File: tb/tb_i2s_apb_regfile.sv
// Directed bench for i2s_apb_regfile: APB reads/writes, Tx drain and Rx fill against a scoreboard.
module tb_i2s_apb_regfile;
    logic        pclk = 1'b0;
    logic        preset, psel, penable, pwrite;
    logic [7:0]  paddr;
    logic [31:0] pwdata, prdata;
    logic        pready, pslverr;
    logic [12:0] flags;
    logic [14:0] controls;
    logic        tx_full, tx_wen, rx_empty, rx_ren, irq;
    logic [31:0] tx_data;
    logic [31:0] rx_data = '0;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct { logic [31:0] data; logic err; } exp_t;
    exp_t        sb_q[$];
    logic [31:0] tx_exp[$];

    logic [31:0] rx_words [8];
    int rx_idx = 0;
    int rx_num = 0;
    int rx_ren_cnt = 0;

    localparam logic [12:0] FLAGS = 13'h0A5C;

    always #5 pclk = ~pclk;

    i2s_apb_regfile dut (
        .pclk(pclk), .preset(preset), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata),
`ifdef I2S_REGFILE_PSTRB_EN
        .pstrb(4'hF),
`endif
        .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .flags(flags), .controls(controls),
        .tx_full(tx_full), .tx_wen(tx_wen), .tx_data(tx_data),
        .rx_empty(rx_empty), .rx_ren(rx_ren), .rx_data(rx_data), .irq(irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Rx FIFO model: word appears on rx_data the cycle after rx_ren.
    assign rx_empty = (rx_idx >= rx_num);
    always @(posedge pclk) begin
        if (rx_ren) begin
            rx_data <= rx_words[rx_idx];
            rx_idx  <= rx_idx + 1;
        end
    end

    always @(negedge pclk) begin
        if (rx_ren)
            rx_ren_cnt++;
        if (tx_wen) begin
            if (tx_exp.size() == 0) begin
                check("tx_wen_unexpected", {31'b0, tx_wen}, 32'h0);
            end else begin
                check("tx_data", tx_data, tx_exp.pop_front());
            end
        end
    end

    task automatic apb(input logic wr, input logic [7:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic er);
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        @(negedge pclk);
        penable = 1'b1;
        #1;
        rd = prdata;
        er = pslverr;
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic apb_chk(input string tag, input logic wr, input logic [7:0] a,
                           input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_err);
        logic [31:0] rd;
        logic        er;
        exp_t        e;
        sb_q.push_back('{data: exp_rd, err: exp_err});
        apb(wr, a, d, rd, er);
        e = sb_q.pop_front();
        if (!wr)
            check({tag, ".prdata"}, rd, e.data);
        check({tag, ".pslverr"}, {31'b0, er}, {31'b0, e.err});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge pclk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        preset = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; flags = FLAGS; tx_full = 1'b0;
        idle(3);
        preset = 1'b1;

        // Reset state
        check("rst.irq", {31'b0, irq}, 32'h0);
        check("rst.tx_wen", {31'b0, tx_wen}, 32'h0);
        check("rst.rx_ren", {31'b0, rx_ren}, 32'h0);
        check("rst.prdata_idle", prdata, 32'h0);
        apb_chk("rst.ctrl", 1'b0, 8'h00, 0, 32'h0000_06D5, 1'b0);
        apb_chk("rst.irq_en", 1'b0, 8'h10, 0, 32'h0, 1'b0);
        apb_chk("rst.irq_stat", 1'b0, 8'h14, 0, 32'h1, 1'b0);
        apb_chk("rst.status", 1'b0, 8'h04, 0, {19'h0, FLAGS}, 1'b0);

        // CTRL read/write
        apb_chk("ctrl.wr", 1'b1, 8'h00, 32'h1234_7FFF, 0, 1'b0);
        apb_chk("ctrl.rd", 1'b0, 8'h00, 0, 32'h0000_7FFF, 1'b0);
        check("ctrl.controls", {17'h0, controls}, 32'h0000_7FFF);

        // Tx buffer fill while FIFO full, overflow, then drain
        tx_full = 1'b1;
        tx_exp.push_back(32'hA1);
        apb_chk("tx.wr0", 1'b1, 8'h08, 32'hA1, 0, 1'b0);
        tx_exp.push_back(32'hB2);
        apb_chk("tx.wr1", 1'b1, 8'h08, 32'hB2, 0, 1'b0);
        apb_chk("tx.ovf", 1'b1, 8'h08, 32'hC3, 0, 1'b1);
        apb_chk("tx.status", 1'b0, 8'h04, 0, {8'h02, 8'h00, 3'b0, FLAGS}, 1'b0);
        apb_chk("tx.stat_full", 1'b0, 8'h14, 0, 32'h4, 1'b0);
        tx_full = 1'b0;
        @(negedge pclk); check("tx.wen_c1", {31'b0, tx_wen}, 32'h1);
        @(negedge pclk); check("tx.wen_c2", {31'b0, tx_wen}, 32'h1);
        @(negedge pclk); check("tx.wen_c3", {31'b0, tx_wen}, 32'h0);
        check("tx.drained", tx_exp.size(), 32'h0);
        apb_chk("tx.stat_drained", 1'b0, 8'h14, 0, 32'h5, 1'b0);
        apb_chk("w1c.ovf", 1'b1, 8'h14, 32'h4, 0, 1'b0);
        apb_chk("w1c.ovf_rd", 1'b0, 8'h14, 0, 32'h1, 1'b0);
        apb_chk("w1c.level", 1'b1, 8'h14, 32'h3, 0, 1'b0);
        apb_chk("w1c.level_rd", 1'b0, 8'h14, 0, 32'h1, 1'b0);

        // Rx fill from the FIFO model
        rx_words[0] = 32'h11; rx_words[1] = 32'h22; rx_words[2] = 32'h33;
        rx_num = 3;
        idle(12);
        check("rx.ren_cnt2", rx_ren_cnt, 2);
        apb_chk("rx.status2", 1'b0, 8'h04, 0, {8'h00, 8'h02, 3'b0, FLAGS}, 1'b0);
        apb_chk("rx.stat", 1'b0, 8'h14, 0, 32'h3, 1'b0);
        apb_chk("rx.pop0", 1'b0, 8'h0C, 0, 32'h11, 1'b0);
        apb_chk("rx.pop1", 1'b0, 8'h0C, 0, 32'h22, 1'b0);
        idle(6);
        check("rx.ren_cnt3", rx_ren_cnt, 3);
        apb_chk("rx.status1", 1'b0, 8'h04, 0, {8'h00, 8'h01, 3'b0, FLAGS}, 1'b0);
        apb_chk("rx.pop2", 1'b0, 8'h0C, 0, 32'h33, 1'b0);
        apb_chk("rx.status0", 1'b0, 8'h04, 0, {19'h0, FLAGS}, 1'b0);

        // Underflow and interrupt timing
        apb_chk("irq.en_wr", 1'b1, 8'h10, 32'h8, 0, 1'b0);
        apb_chk("irq.en_rd", 1'b0, 8'h10, 0, 32'h8, 1'b0);
        apb_chk("rx.udf", 1'b0, 8'h0C, 0, 32'h0, 1'b1);
        check("irq.rise_before", {31'b0, irq}, 32'h0);
        @(negedge pclk); check("irq.rise_after", {31'b0, irq}, 32'h1);
        apb_chk("irq.stat_udf", 1'b0, 8'h14, 0, 32'h9, 1'b0);
        apb_chk("irq.w1c", 1'b1, 8'h14, 32'h8, 0, 1'b0);
        check("irq.fall_before", {31'b0, irq}, 32'h1);
        @(negedge pclk); check("irq.fall_after", {31'b0, irq}, 32'h0);

        // Error responses
        apb_chk("err.unmapped_rd", 1'b0, 8'h18, 0, 32'h0, 1'b1);
        apb_chk("err.unmapped_wr", 1'b1, 8'h18, 32'hFFFF_FFFF, 0, 1'b1);
        apb_chk("err.misaligned", 1'b0, 8'h01, 0, 32'h0, 1'b1);
        apb_chk("err.status_wr", 1'b1, 8'h04, 32'hFFFF_FFFF, 0, 1'b1);
        apb_chk("err.status_same", 1'b0, 8'h04, 0, {19'h0, FLAGS}, 1'b0);
        apb_chk("err.txdata_rd", 1'b0, 8'h08, 0, 32'h0, 1'b1);
        apb_chk("err.rxdata_wr", 1'b1, 8'h0C, 32'h5A, 0, 1'b1);

        // Reset in the middle of operation: Tx entries and the in-flight read are discarded
        apb_chk("mid.ctrl_wr", 1'b1, 8'h00, 32'h0, 0, 1'b0);
        tx_full = 1'b1;
        apb_chk("mid.tx0", 1'b1, 8'h08, 32'h55, 0, 1'b0);
        apb_chk("mid.tx1", 1'b1, 8'h08, 32'h66, 0, 1'b0);
        apb_chk("mid.status", 1'b0, 8'h04, 0, {8'h02, 8'h00, 3'b0, FLAGS}, 1'b0);
        rx_words[3] = 32'h44;
        rx_num = 4;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge pclk);
            if (rx_ren) seen = 1'b1;
        end
        check("mid.rx_ren_seen", {31'b0, seen}, 32'h1);
        preset = 1'b0;
        @(negedge pclk);
        preset = 1'b1;
        tx_full = 1'b0;
        idle(6);
        check("mid.tx_wen", {31'b0, tx_wen}, 32'h0);
        check("mid.irq", {31'b0, irq}, 32'h0);
        check("mid.ren_cnt", rx_ren_cnt, 4);
        apb_chk("mid.status0", 1'b0, 8'h04, 0, {19'h0, FLAGS}, 1'b0);
        apb_chk("mid.ctrl", 1'b0, 8'h00, 0, 32'h0000_06D5, 1'b0);
        apb_chk("mid.irq_en", 1'b0, 8'h10, 0, 32'h0, 1'b0);
        apb_chk("mid.irq_stat", 1'b0, 8'h14, 0, 32'h1, 1'b0);
        check("mid.pready", {31'b0, pready}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
